// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle ARM-subset control unit:
//   - state_t      : instruction-sequencing FSM states (4-bit encoding)
//   - ALU_*        : ALUControl encodings
//   - RES_*        : ResultSrc mux selects
//   - SRCB_*       : ALUSrcB mux selects
//   - OP_*         : instruction Op field classes
// No ports (package).
// ---------------------------------------------------------------------------
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/condcheck.sv
// ---------------------------------------------------------------------------
// condcheck
// Evaluates an ARM condition field against the stored NZCV flags.
// Ports:
//   Cond   in  4 : instruction condition field
//   Flags  in  4 : {N,Z,C,V}
//   CondEx out 1 : 1 when the instruction should execute
// Cond=1111 is treated as never-execute.
// ---------------------------------------------------------------------------
module condcheck (
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic w_neg;
   logic w_zero;
   logic w_carry;
   logic w_overflow;
   logic w_ge;

   assign {w_neg, w_zero, w_carry, w_overflow} = Flags;
   assign w_ge = (w_neg == w_overflow);

   // Standard ARM condition-code table; GE/LT/GT/LE compare N against V.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = w_zero;
         4'b0001: CondEx = ~w_zero;
         4'b0010: CondEx = w_carry;
         4'b0011: CondEx = ~w_carry;
         4'b0100: CondEx = w_neg;
         4'b0101: CondEx = ~w_neg;
         4'b0110: CondEx = w_overflow;
         4'b0111: CondEx = ~w_overflow;
         4'b1000: CondEx = w_carry & ~w_zero;
         4'b1001: CondEx = ~(w_carry & ~w_zero);
         4'b1010: CondEx = w_ge;
         4'b1011: CondEx = ~w_ge;
         4'b1100: CondEx = ~w_zero & w_ge;
         4'b1101: CondEx = ~(~w_zero & w_ge);
         4'b1110: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_aludec.sv
// ---------------------------------------------------------------------------
// mc_aludec
// Combinational ALU function decoder.
// Ports:
//   i_aluOp      in  1 : 1 in the execute states, 0 elsewhere (forces ADD)
//   i_funct      in  6 : instruction Funct field {I, cmd[3:0], S}
//   o_aluControl out 2 : 00 ADD, 01 SUB, 10 AND, 11 ORR
//   o_flagW      out 2 : [1] enables N/Z update, [0] enables C/V update
// ---------------------------------------------------------------------------
module mc_aludec
   import mc_pkg::*;
(
   input  logic       i_aluOp,
   input  logic [5:0] i_funct,
   output logic [1:0] o_aluControl,
   output logic [1:0] o_flagW
);

   logic [3:0] w_cmd;
   logic       w_arith;

   assign w_cmd   = i_funct[4:1];
   assign w_arith = (w_cmd == 4'b0100) || (w_cmd == 4'b0010);

   // Outside the execute states the ALU is only ever used as an adder
   // (PC+4, address and branch-target arithmetic) and must never touch
   // the flags. Only ADD/SUB produce meaningful carry/overflow, so the
   // logical ops with S set update N and Z alone.
   always_comb begin
      o_aluControl = ALU_ADD;
      o_flagW      = 2'b00;
      if (i_aluOp) begin
         case (w_cmd)
            4'b0100: o_aluControl = ALU_ADD;
            4'b0010: o_aluControl = ALU_SUB;
            4'b0000: o_aluControl = ALU_AND;
            4'b1100: o_aluControl = ALU_ORR;
            default: o_aluControl = ALU_ADD;
         endcase
         o_flagW[1] = i_funct[0];
         o_flagW[0] = i_funct[0] & w_arith;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control unit of the multicycle ARM-subset datapath: sequencing FSM,
// ALU decoder, NZCV flag register and the registered condition-execute bit.
// Optional feature macro: MC_MEMRDY_EN (adds the mem_ready handshake port).
// Ports:
//   clk, reset         : clock (rising edge), async active-high reset
//   mem_ready          : memory handshake (only with MC_MEMRDY_EN)
//   Op, Funct, Rd, Cond: instruction fields [27:26],[25:20],[15:12],[31:28]
//   ALUFlags           : {N,Z,C,V} from the ALU
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegSrc, RegWrite : datapath enables and selects
// ---------------------------------------------------------------------------
module multicycle_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
`ifdef MC_MEMRDY_EN
   input  logic       mem_ready,
`endif
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       RegWrite
);

   state_t     r_state;
   logic [3:0] r_flags;
   logic       r_condExReg;

   logic       w_memReady;
   logic       w_nextPc;
   logic       w_branch;
   logic       w_regW;
   logic       w_memW;
   logic       w_aluOp;
   logic       w_pcs;
   logic       w_condEx;
   logic [1:0] w_flagW;

`ifdef MC_MEMRDY_EN
   assign w_memReady = mem_ready;
`else
   assign w_memReady = 1'b1;
`endif

   mc_aludec u_aludec (
      .i_aluOp      (w_aluOp),
      .i_funct      (Funct),
      .o_aluControl (ALUControl),
      .o_flagW      (w_flagW)
   );

   condcheck u_condcheck (
      .Cond   (Cond),
      .Flags  (r_flags),
      .CondEx (w_condEx)
   );

   // Raw (ungated) Moore controls for each state. FETCH only commits the
   // instruction register and PC+4 once memory has delivered the word; in
   // the single-cycle-memory build w_memReady is tied high.
   always_comb begin
      w_nextPc  = 1'b0;
      w_branch  = 1'b0;
      w_regW    = 1'b0;
      w_memW    = 1'b0;
      w_aluOp   = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_RD2;
      ResultSrc = RES_ALUOUT;
      case (r_state)
         S_FETCH: begin
            IRWrite   = w_memReady;
            w_nextPc  = w_memReady;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_MEMADR: ALUSrcB = SRCB_EXTIMM;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            w_regW    = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            w_memW = 1'b1;
         end
         S_EXECR: w_aluOp = 1'b1;
         S_EXECI: begin
            ALUSrcB = SRCB_EXTIMM;
            w_aluOp = 1'b1;
         end
         S_ALUWB: w_regW = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = SRCB_EXTIMM;
            ResultSrc = RES_ALURESULT;
            w_branch  = 1'b1;
         end
         default: begin
            w_nextPc = 1'b0;
         end
      endcase
   end

   // Architectural writes are suppressed by a failed condition, except the
   // unconditional PC+4 in FETCH. A write to R15 redirects the PC.
   assign w_pcs    = w_branch | (w_regW & (Rd == 4'd15));
   assign RegWrite = w_regW & r_condExReg;
   assign MemWrite = w_memW & r_condExReg;
   assign PCWrite  = w_nextPc | (w_pcs & r_condExReg);
   assign ImmSrc   = Op;
   assign RegSrc   = {(Op == OP_MEM), (Op == OP_BR)};

   // State sequencing, condition capture and flag update. The condition is
   // sampled once, on the edge leaving DECODE, so flags written by this
   // instruction's execute step cannot alter its own write gating. Unused
   // encodings recover to FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_flags     <= 4'b0000;
         r_condExReg <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH:  r_state <= w_memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (Op)
                  OP_MEM:  r_state <= S_MEMADR;
                  OP_DP:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
                  OP_BR:   r_state <= S_BRANCH;
                  default: r_state <= S_FETCH;
               endcase
            end
            S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  r_state <= w_memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  r_state <= S_FETCH;
            S_MEMWR:  r_state <= w_memReady ? S_FETCH : S_MEMWR;
            S_EXECR:  r_state <= S_ALUWB;
            S_EXECI:  r_state <= S_ALUWB;
            S_ALUWB:  r_state <= S_FETCH;
            S_BRANCH: r_state <= S_FETCH;
            default:  r_state <= S_FETCH;
         endcase

         if (r_state == S_DECODE) begin
            r_condExReg <= w_condEx;
         end

         if (w_flagW[1] & r_condExReg) begin
            r_flags[3:2] <= ALUFlags[3:2];
         end
         if (w_flagW[0] & r_condExReg) begin
            r_flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl: a per-cycle table of instruction
// fields with hand-computed control outputs and flag values, followed by
// hand-written sequences for mid-instruction reset and (with MC_MEMRDY_EN)
// memory-ready stalls.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic [3:0]  cond;
      logic [3:0]  aluFlags;
      logic [15:0] expOut;
      logic [3:0]  expFlags;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       memReady;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic       RegWrite;

   logic [15:0] actOut;
   vec_t        vecs[$];
   vec_t        ldr;
   int          checks;
   int          errors;

   multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
`ifdef MC_MEMRDY_EN
      .mem_ready  (memReady),
`endif
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .RegWrite   (RegWrite)
   );

   assign actOut = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite};

   // Free-running clock, first rising edge at 5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack expected outputs in the same field order as actOut.
   function automatic logic [15:0] pk(input logic pcw, input logic adr,
                                      input logic memw, input logic irw,
                                      input logic [1:0] rs, input logic a,
                                      input logic [1:0] b, input logic [1:0] alc,
                                      input logic [1:0] imm, input logic [1:0] regsrc,
                                      input logic regw);
      return {pcw, adr, memw, irw, rs, a, b, alc, imm, regsrc, regw};
   endfunction

   function automatic logic [15:0] fetchOut(input logic [1:0] imm, input logic [1:0] regsrc);
      return pk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, imm, regsrc, 1'b0);
   endfunction

   function automatic logic [15:0] decodeOut(input logic [1:0] imm, input logic [1:0] regsrc);
      return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, imm, regsrc, 1'b0);
   endfunction

   // Append one cycle's record to the vector table.
   task automatic addVec(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] cond,
                         input logic [3:0] aluf, input logic [15:0] expOut,
                         input logic [3:0] expFlags);
      vec_t v;
      v.op = op; v.funct = funct; v.rd = rd; v.cond = cond;
      v.aluFlags = aluf; v.expOut = expOut; v.expFlags = expFlags;
      vecs.push_back(v);
   endtask

   // Drive instruction fields for the current cycle.
   task automatic applyStimulus(input vec_t v);
      Op = v.op; Funct = v.funct; Rd = v.rd; Cond = v.cond; ALUFlags = v.aluFlags;
   endtask

   // Compare the control word and the flag register against expectations.
   task automatic checkOutput(input string name, input logic [15:0] expOut,
                              input logic [3:0] expFlags);
      checks++;
      if (actOut !== expOut) begin
         errors++;
         $display("[TB] FAIL %s ctrl got=%b want=%b", name, actOut, expOut);
      end
      checks++;
      if (dut.r_flags !== expFlags) begin
         errors++;
         $display("[TB] FAIL %s flags got=%b want=%b", name, dut.r_flags, expFlags);
      end
   endtask

   task automatic checkCondEx(input string name, input logic exp);
      checks++;
      if (dut.r_condExReg !== exp) begin
         errors++;
         $display("[TB] FAIL %s condEx got=%b want=%b", name, dut.r_condExReg, exp);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      memReady = 1'b1;

      // STREQ with Z=0: walks to MEMWR but never strobes memory.
      addVec(2'b01, 6'b011000, 4'd3, 4'b0000, 4'b1111, fetchOut(2'b01, 2'b10), 4'b0000);
      addVec(2'b01, 6'b011000, 4'd3, 4'b0000, 4'b1111, decodeOut(2'b01, 2'b10), 4'b0000);
      addVec(2'b01, 6'b011000, 4'd3, 4'b0000, 4'b1111,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 0), 4'b0000);
      addVec(2'b01, 6'b011000, 4'd3, 4'b0000, 4'b1111,
             pk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0), 4'b0000);
      // ADDS R1, immediate: flags 0100 captured in EXECI.
      addVec(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b1111, fetchOut(2'b00, 2'b00), 4'b0000);
      addVec(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b1111, decodeOut(2'b00, 2'b00), 4'b0000);
      addVec(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b0100,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0), 4'b0000);
      addVec(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b1111,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 4'b0100);
      // BNE with Z=1: branch suppressed.
      addVec(2'b10, 6'b000000, 4'd0, 4'b0001, 4'b1111, fetchOut(2'b10, 2'b01), 4'b0100);
      addVec(2'b10, 6'b000000, 4'd0, 4'b0001, 4'b1111, decodeOut(2'b10, 2'b01), 4'b0100);
      addVec(2'b10, 6'b000000, 4'd0, 4'b0001, 4'b1111,
             pk(0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b10, 2'b01, 0), 4'b0100);
      // SUBS R15, register: PC redirected in ALUWB, full NZCV load.
      addVec(2'b00, 6'b000101, 4'd15, 4'b1110, 4'b1111, fetchOut(2'b00, 2'b00), 4'b0100);
      addVec(2'b00, 6'b000101, 4'd15, 4'b1110, 4'b1111, decodeOut(2'b00, 2'b00), 4'b0100);
      addVec(2'b00, 6'b000101, 4'd15, 4'b1110, 4'b1011,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0), 4'b0100);
      addVec(2'b00, 6'b000101, 4'd15, 4'b1110, 4'b1111,
             pk(1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 4'b1011);
      // ANDS R4, immediate: only N,Z updated (1011 -> 0111).
      addVec(2'b00, 6'b100001, 4'd4, 4'b1110, 4'b1111, fetchOut(2'b00, 2'b00), 4'b1011);
      addVec(2'b00, 6'b100001, 4'd4, 4'b1110, 4'b1111, decodeOut(2'b00, 2'b00), 4'b1011);
      addVec(2'b00, 6'b100001, 4'd4, 4'b1110, 4'b0100,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 4'b1011);
      addVec(2'b00, 6'b100001, 4'd4, 4'b1110, 4'b1111,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 4'b0111);
      // Op=11 NOP: two cycles.
      addVec(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b1111, fetchOut(2'b11, 2'b00), 4'b0111);
      addVec(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b1111, decodeOut(2'b11, 2'b00), 4'b0111);
      // B AL: PC written in FETCH and BRANCH.
      addVec(2'b10, 6'b000000, 4'd0, 4'b1110, 4'b1111, fetchOut(2'b10, 2'b01), 4'b0111);
      addVec(2'b10, 6'b000000, 4'd0, 4'b1110, 4'b1111, decodeOut(2'b10, 2'b01), 4'b0111);
      addVec(2'b10, 6'b000000, 4'd0, 4'b1110, 4'b1111,
             pk(1, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b10, 2'b01, 0), 4'b0111);
      // LDR R2: five cycles.
      addVec(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b1111, fetchOut(2'b01, 2'b10), 4'b0111);
      addVec(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b1111, decodeOut(2'b01, 2'b10), 4'b0111);
      addVec(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b1111,
             pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 0), 4'b0111);
      addVec(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b1111,
             pk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0), 4'b0111);
      addVec(2'b01, 6'b011001, 4'd2, 4'b1110, 4'b1111,
             pk(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b01, 2'b10, 1), 4'b0111);

      ldr = vecs[vecs.size() - 1];

      // Reset state: FETCH controls, cleared flags and condition bit.
      reset = 1'b1;
      applyStimulus(ldr);
      @(negedge clk);
      checkOutput("reset", fetchOut(2'b01, 2'b10), 4'b0000);
      checkCondEx("reset", 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expFlags);
         @(posedge clk);
         #1;
      end

      // Mid-instruction reset: abort an LDR in MEMRD.
      applyStimulus(ldr);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("abort_memrd",
                  pk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0), 4'b0111);
      reset = 1'b1;
      #1;
      checkOutput("abort_now", fetchOut(2'b01, 2'b10), 4'b0000);
      checkCondEx("abort_now", 1'b0);
      @(posedge clk);
      #1;
      checkOutput("abort_hold", fetchOut(2'b01, 2'b10), 4'b0000);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("resume_fetch", fetchOut(2'b01, 2'b10), 4'b0000);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("resume_decode", decodeOut(2'b01, 2'b10), 4'b0000);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("resume_memadr",
                  pk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 0), 4'b0000);

`ifdef MC_MEMRDY_EN
      // Memory stalls: FETCH waits for data, STR holds MemWrite in MEMWR.
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      Op = 2'b01; Funct = 6'b011000; Rd = 4'd5; Cond = 4'b1110; ALUFlags = 4'b1111;
      memReady = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput($sformatf("fetch_stall%0d", i),
                     pk(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b10, 0), 4'b0000);
         @(posedge clk);
         #1;
      end
      memReady = 1'b1;
      @(negedge clk);
      checkOutput("fetch_go", fetchOut(2'b01, 2'b10), 4'b0000);
      repeat (3) @(posedge clk);
      #1 memReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) memReady = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("memwr_hold%0d", i),
                     pk(0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0), 4'b0000);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkOutput("memwr_done", fetchOut(2'b01, 2'b10), 4'b0000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
